// File: rtl/coin_accumulator.sv
// rtl/coin_accumulator.sv - coin credit engine: multi-channel credit, vend handshake, serial refund.
// Optional idle auto-refund is enabled by defining COIN_TIMEOUT_EN.
module coin_accumulator #(
  parameter int NUM_COINS = 2,
  parameter int TOTAL_W = 4,
  parameter logic [NUM_COINS*TOTAL_W-1:0] COIN_VALUES = {4'd5, 4'd1},
  parameter int PRICE = 3,
  parameter int MAX_TOTAL = 15,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_COINS-1:0] coin,
  input  logic                 buy,
  input  logic                 cancel,
  input  logic                 vend_ack,
  output logic [TOTAL_W-1:0]   total,
  output logic                 credit_ok,
  output logic                 vend_req,
  output logic                 refund_pulse,
  output logic                 coin_reject,
  output logic                 busy
);

  // One guard bit above the worst-case coin sum so total+sum cannot wrap.
  localparam int SUM_W = TOTAL_W + $clog2(NUM_COINS) + 1;
  localparam logic [TOTAL_W-1:0] PRICE_V = TOTAL_W'(PRICE);
  localparam logic [SUM_W-1:0] MAX_V = SUM_W'(MAX_TOTAL);

  typedef enum logic [1:0] {CREDIT, VEND, REFUND} state_t;
  state_t state;

  logic [SUM_W-1:0]   sum;
  logic [SUM_W-1:0]   new_total;
  logic [TOTAL_W-1:0] remain;
  logic               any_coin;
  logic               fits;
  logic               timeout_hit;
  logic               cancel_take;
  logic               buy_take;
  logic               coin_accept;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (coin[i]) sum = sum + SUM_W'(COIN_VALUES[i*TOTAL_W +: TOTAL_W]);
    end
  end

  assign any_coin    = |coin;
  assign new_total   = SUM_W'(total) + sum;
  assign fits        = (new_total <= MAX_V);
  assign remain      = total - PRICE_V;
  assign credit_ok   = (total >= PRICE_V);
  assign cancel_take = (state == CREDIT) && (cancel || timeout_hit) && (total != '0);
  assign buy_take    = (state == CREDIT) && !cancel_take && buy && credit_ok;
  assign coin_accept = (state == CREDIT) && !cancel_take && !buy_take && any_coin && fits;

`ifdef COIN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] idle_count;

  assign timeout_hit = (state == CREDIT) && (total != '0) &&
                       (idle_count == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || state != CREDIT || total == '0 || coin_accept || cancel_take || buy_take)
      idle_count <= '0;
    else
      idle_count <= idle_count + 1'b1;
  end
`else
  // Feature disabled: the timeout never fires.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CREDIT;
      total        <= '0;
      vend_req     <= 1'b0;
      refund_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      coin_reject  <= 1'b0;
      refund_pulse <= 1'b0;
      case (state)
        CREDIT: begin
          if (cancel_take) begin
            state       <= REFUND;
            busy        <= 1'b1;
            coin_reject <= any_coin;
          end else if (buy_take) begin
            state       <= VEND;
            vend_req    <= 1'b1;
            busy        <= 1'b1;
            coin_reject <= any_coin;
          end else if (any_coin) begin
            if (fits) total <= new_total[TOTAL_W-1:0];
            else      coin_reject <= 1'b1;
          end
        end
        VEND: begin
          coin_reject <= any_coin;
          if (vend_ack) begin
            total    <= remain;
            vend_req <= 1'b0;
            if (remain != '0) begin
              state <= REFUND;
            end else begin
              state <= CREDIT;
              busy  <= 1'b0;
            end
          end
        end
        REFUND: begin
          coin_reject <= any_coin;
          if (total != '0) begin
            total        <= total - 1'b1;
            refund_pulse <= 1'b1;
          end
          // Leave together with the last pulse so busy drops as total reaches 0.
          if (total <= TOTAL_W'(1)) begin
            state <= CREDIT;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= CREDIT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_accumulator.sv
// tb/tb_coin_accumulator.sv - scoreboard bench for coin_accumulator (default build).
module tb_coin_accumulator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] coin = 2'b00;
  logic       buy = 1'b0;
  logic       cancel = 1'b0;
  logic       vend_ack = 1'b0;
  logic [3:0] total;
  logic       credit_ok;
  logic       vend_req;
  logic       refund_pulse;
  logic       coin_reject;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int step = 0;

  typedef struct {
    int   t;
    logic vr;
    logic rp;
    logic rj;
    logic bz;
  } exp_t;

  exp_t exp_q[$];

  coin_accumulator dut (
    .clk(clk), .reset(reset), .coin(coin), .buy(buy), .cancel(cancel),
    .vend_ack(vend_ack), .total(total), .credit_ok(credit_ok), .vend_req(vend_req),
    .refund_pulse(refund_pulse), .coin_reject(coin_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  // Apply one cycle of stimulus and queue the outputs expected after that edge.
  task automatic drv(input logic rst, input logic [1:0] c, input logic b, input logic cn,
                     input logic ack, input int t, input logic vr, input logic rp,
                     input logic rj, input logic bz);
    exp_t e;
    @(negedge clk);
    reset = rst; coin = c; buy = b; cancel = cn; vend_ack = ack;
    e.t = t; e.vr = vr; e.rp = rp; e.rj = rj; e.bz = bz;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int t, input logic vr, input logic rp, input logic bz);
    drv(0, 2'b00, 0, 0, 0, t, vr, rp, 0, bz);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        step++;
        check($sformatf("s%0d total", step), int'(total), e.t);
        check($sformatf("s%0d credit_ok", step), int'(credit_ok), int'(e.t >= 3));
        check($sformatf("s%0d vend_req", step), int'(vend_req), int'(e.vr));
        check($sformatf("s%0d refund_pulse", step), int'(refund_pulse), int'(e.rp));
        check($sformatf("s%0d coin_reject", step), int'(coin_reject), int'(e.rj));
        check($sformatf("s%0d busy", step), int'(busy), int'(e.bz));
      end
    end
  end

  initial begin
    // Reset state
    drv(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    // Cancel with zero credit is ignored
    drv(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0);
    // Single small coins
    for (int i = 1; i <= 3; i++) drv(0, 2'b01, 0, 0, 0, i, 0, 0, 0, 0);
    // Drain 3 via cancel
    drv(0, 2'b00, 0, 1, 0, 3, 0, 0, 0, 1);
    idle(2, 0, 1, 1);
    idle(1, 0, 1, 1);
    idle(0, 0, 1, 0);
    idle(0, 0, 0, 0);
    // Simultaneous coins summed, then saturation reject
    drv(0, 2'b11, 0, 0, 0, 6, 0, 0, 0, 0);
    drv(0, 2'b10, 0, 0, 0, 11, 0, 0, 0, 0);
    drv(0, 2'b10, 0, 0, 0, 11, 0, 0, 1, 0);
    idle(11, 0, 0, 0);
    // Drain 11
    drv(0, 2'b00, 0, 1, 0, 11, 0, 0, 0, 1);
    for (int i = 10; i >= 0; i--) idle(i, 0, 1, (i != 0));
    idle(0, 0, 0, 0);
    // Vend with delayed ack, coin rejected while vending
    drv(0, 2'b11, 0, 0, 0, 6, 0, 0, 0, 0);
    drv(0, 2'b00, 1, 0, 0, 6, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) drv(0, (i == 2) ? 2'b01 : 2'b00, 0, 0, 0, 6, 1, 0, (i == 2), 1);
    drv(0, 2'b00, 0, 0, 1, 3, 0, 0, 0, 1);
    idle(2, 0, 1, 1);
    idle(1, 0, 1, 1);
    idle(0, 0, 1, 0);
    idle(0, 0, 0, 0);
    // Cancel beats a coin, coin during refund rejected
    for (int i = 1; i <= 4; i++) drv(0, 2'b01, 0, 0, 0, i, 0, 0, 0, 0);
    drv(0, 2'b01, 0, 1, 0, 4, 0, 0, 1, 1);
    idle(3, 0, 1, 1);
    drv(0, 2'b10, 0, 0, 0, 2, 0, 1, 1, 1);
    idle(1, 0, 1, 1);
    idle(0, 0, 1, 0);
    idle(0, 0, 0, 0);
    // Buy below price is ignored
    drv(0, 2'b01, 0, 0, 0, 1, 0, 0, 0, 0);
    drv(0, 2'b01, 0, 0, 0, 2, 0, 0, 0, 0);
    drv(0, 2'b00, 1, 0, 0, 2, 0, 0, 0, 0);
    idle(2, 0, 0, 0);
    // Buy beats a coin; vend with no remainder returns straight to credit
    drv(0, 2'b01, 0, 0, 0, 3, 0, 0, 0, 0);
    drv(0, 2'b10, 1, 0, 0, 3, 1, 0, 1, 1);
    drv(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    // Reset mid-refund
    drv(0, 2'b10, 0, 0, 0, 5, 0, 0, 0, 0);
    drv(0, 2'b00, 0, 1, 0, 5, 0, 0, 0, 1);
    idle(4, 0, 1, 1);
    idle(3, 0, 1, 1);
    drv(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    // Reset mid-vend
    drv(0, 2'b11, 0, 0, 0, 6, 0, 0, 0, 0);
    drv(0, 2'b00, 1, 0, 0, 6, 1, 0, 0, 1);
    drv(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    check("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
